max_q_finder: RTL

- Upstream neighbour of the Q-value update stage.
- For the board state reached after a move, scans that state's nine Q-table entries (one per cell) and selects the largest Q among legal (empty) cells.
- Produces `max_Q`, the input the update stage multiplies by gamma, plus the arg-max action for greedy play.
- Reads the Q-table through a synchronous one-read-port RAM interface: one request per cycle, one-cycle read latency.

---
 rtl/q_pkg.sv | 15 +
 rtl/max_q_finder_if.sv | 25 ++
 rtl/max_q_finder.sv | 103 ++++++++++
 3 files changed

// File: rtl/q_pkg.sv
// Shared constants and FSM state type for the max-Q scan.
package q_pkg;
  localparam int Q_W     = 16;
  localparam int N_CELLS = 9;
  localparam int ADDR_W  = 4;

  localparam logic [ADDR_W-1:0] NO_ACTION = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;
endpackage

// File: rtl/max_q_finder_if.sv
// Scan control, Q-table read port and result bundle of max_q_finder.
interface max_q_finder_if;
  import q_pkg::*;

  logic                     start;
  logic [N_CELLS-1:0]       legal_mask;
  logic                     q_rd_en;
  logic [ADDR_W-1:0]        q_rd_addr;
  logic signed [Q_W-1:0]    q_rd_data;
  logic                     busy;
  logic                     done;
  logic signed [Q_W-1:0]    max_Q;
  logic [ADDR_W-1:0]        max_action;
  logic                     no_legal;

  modport master (
    input  start, legal_mask, q_rd_data,
    output q_rd_en, q_rd_addr, busy, done, max_Q, max_action, no_legal
  );

  modport slave (
    output start, legal_mask, q_rd_data,
    input  q_rd_en, q_rd_addr, busy, done, max_Q, max_action, no_legal
  );
endinterface

// File: rtl/max_q_finder.sv
// Scans the nine Q entries of a state and returns the largest Q among legal
// cells plus its action index; lower index wins ties.
module max_q_finder
  import q_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  max_q_finder_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_CELLS - 1);

  state_t                state;
  logic [N_CELLS-1:0]    mask;
  logic                  tag_vld_p1;
  logic [ADDR_W-1:0]     tag_addr_p1;
  logic                  found;
  logic signed [Q_W-1:0] best_q;
  logic [ADDR_W-1:0]     best_a;
  logic                  win;

  function automatic logic takes_lead(input logic have,
                                      input logic signed [Q_W-1:0] cand,
                                      input logic signed [Q_W-1:0] best);
    return !have || (cand > best);
  endfunction

  always_comb begin
    win = tag_vld_p1 && mask[tag_addr_p1] && takes_lead(found, bus.q_rd_data, best_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      mask           <= '0;
      tag_vld_p1     <= 1'b0;
      tag_addr_p1    <= '0;
      found          <= 1'b0;
      best_q         <= '0;
      best_a         <= '0;
      bus.q_rd_en    <= 1'b0;
      bus.q_rd_addr  <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.max_Q      <= '0;
      bus.max_action <= '0;
      bus.no_legal   <= 1'b0;
    end else begin
      // p1: tag each returning RAM word with the request issued last cycle
      tag_vld_p1  <= bus.q_rd_en;
      tag_addr_p1 <= bus.q_rd_addr;
      if (win) begin
        found  <= 1'b1;
        best_q <= bus.q_rd_data;
        best_a <= tag_addr_p1;
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            mask          <= bus.legal_mask;
            found         <= 1'b0;
            best_q        <= '0;
            best_a        <= '0;
            bus.q_rd_en   <= 1'b1;
            bus.q_rd_addr <= '0;
            bus.busy      <= 1'b1;
            state         <= READ;
          end
        end
        READ: begin
          if (bus.q_rd_addr == LAST_ADDR) begin
            bus.q_rd_en <= 1'b0;
            state       <= DRAIN;
          end else begin
            bus.q_rd_addr <= bus.q_rd_addr + 1'b1;
          end
        end
        DRAIN: begin
          // Last word is compared this cycle, so results fold it in directly
          if (!(found || win)) begin
            bus.max_Q      <= '0;
            bus.max_action <= NO_ACTION;
            bus.no_legal   <= 1'b1;
          end else begin
            bus.max_Q      <= win ? bus.q_rd_data : best_q;
            bus.max_action <= win ? tag_addr_p1 : best_a;
            bus.no_legal   <= 1'b0;
          end
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
